peripheral_responder: RTL and testbench

PERIPHERAL_RESPONDER -- requirements
Module: peripheral_responder

---
 rtl/peripheral_responder.sv | 89 ++++++++
 tb/tb_peripheral_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/peripheral_responder.sv
// peripheral_responder: memory-mapped timer, LED, seven-segment and cycle-counter registers
// behind a single-cycle combinational load/store port.
module peripheral_responder #(
    parameter logic [31:0] BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        irqout,
    output logic [7:0]  leds,
    output logic [11:0] digits
);
    logic [31:0] th_q, th_d, tl_q, tl_d, systick_q, systick_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [2:0]  idx;
    logic        wr, ovf, ovf_irq;
    logic        unused_addr_lsbs;

    assign idx              = Address[4:2];
    assign hit              = (Address[31:5] == BASE[31:5]) && (idx <= 3'd5);
    assign wr               = MemWrite && hit;
    assign ovf              = tcon_q[0] && (&tl_q);
    assign ovf_irq          = ovf && tcon_q[1];
    assign systick_d        = systick_q + 32'd1;
    assign unused_addr_lsbs = &{1'b0, Address[1:0]};

    always_comb begin
        ReadData = 32'h0;
        if (MemRead && hit) begin
            case (idx)
                3'd0:    ReadData = th_q;
                3'd1:    ReadData = tl_q;
                3'd2:    ReadData = {29'h0, tcon_q};
                3'd3:    ReadData = {24'h0, led_q};
                3'd4:    ReadData = {20'h0, digi_q};
                3'd5:    ReadData = systick_q;
                default: ReadData = 32'h0;
            endcase
        end
    end

    // Timer step first, then a store overrides; a TCON store keeps an overflow's irq status.
    always_comb begin
        th_d   = th_q;
        tl_d   = tcon_q[0] ? (ovf ? th_q : tl_q + 32'd1) : tl_q;
        tcon_d = {tcon_q[2] | ovf_irq, tcon_q[1:0]};
        led_d  = led_q;
        digi_d = digi_q;
        if (wr) begin
            case (idx)
                3'd0:    th_d   = WriteData;
                3'd1:    tl_d   = WriteData;
                3'd2:    tcon_d = {WriteData[2] | ovf_irq, WriteData[1:0]};
                3'd3:    led_d  = WriteData[7:0];
                3'd4:    digi_d = WriteData[11:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= 32'h0;
            tl_q      <= 32'h0;
            tcon_q    <= 3'h0;
            led_q     <= 8'h0;
            digi_q    <= 12'h0;
            systick_q <= 32'h0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    assign irqout = tcon_q[2];
    assign leds   = led_q;
    assign digits = digi_q;
endmodule

// File: tb/tb_peripheral_responder.sv
// tb_peripheral_responder: randomized and directed checks of peripheral_responder against
// a register-array model of the programmer-visible behaviour.
module tb_peripheral_responder;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData;
    logic        hit;
    logic        irqout;
    logic [7:0]  leds;
    logic [11:0] digits;

    peripheral_responder #(.BASE(BASE)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .hit(hit),
        .irqout(irqout), .leds(leds), .digits(digits)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m [6];
    logic        valid = 1'b0;
    logic [31:0] last_rd;
    logic        last_irq, last_hit;
    logic [7:0]  last_leds;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic in_window(input logic [31:0] a);
        return (a[31:5] == BASE[31:5]) && (a[4:2] <= 3'd5);
    endfunction

    // Model of one bus cycle: registers m[0..5] = TH, TL, TCON, LED, DIGI, SYSTICK.
    task automatic model_edge(input logic [31:0] a, wd, input logic w, rs);
        logic [31:0] n [6];
        logic        ov, irq_set;
        int          k;
        if (rs) begin
            for (int i = 0; i < 6; i++) m[i] = 32'h0;
            return;
        end
        n = m;
        ov = m[2][0] && (m[1] == 32'hFFFF_FFFF);
        irq_set = ov && m[2][1];
        if (m[2][0]) n[1] = ov ? m[0] : m[1] + 32'd1;
        if (irq_set) n[2][2] = 1'b1;
        if (w && in_window(a)) begin
            k = int'(a[4:2]);
            if (k == 0) n[0] = wd;
            if (k == 1) n[1] = wd;
            if (k == 2) n[2] = {29'h0, wd[2] | irq_set, wd[1:0]};
            if (k == 3) n[3] = wd & 32'hFF;
            if (k == 4) n[4] = wd & 32'hFFF;
        end
        n[5] = m[5] + 32'd1;
        m = n;
    endtask

    task automatic cycle(input logic [31:0] a, wd, input logic rd, w, rs);
        logic        eh;
        logic [31:0] er;
        @(negedge clk);
        Address = a; WriteData = wd; MemRead = rd; MemWrite = w; reset = rs;
        #2;
        eh = in_window(a);
        er = (rd && eh) ? m[a[4:2]] : 32'h0;
        last_rd = ReadData; last_irq = irqout; last_hit = hit; last_leds = leds;
        check("hit", {31'h0, hit}, {31'h0, eh});
        if (valid) begin
            check("ReadData", ReadData, er);
            check("irqout", {31'h0, irqout}, {31'h0, m[2][2]});
            check("leds", {24'h0, leds}, m[3]);
            check("digits", {20'h0, digits}, m[4]);
        end
        @(posedge clk);
        model_edge(a, wd, w, rs);
        if (rs) valid = 1'b1;
    endtask

    task automatic idle();
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic wr(input logic [31:0] a, wd);
        cycle(a, wd, 1'b0, 1'b1, 1'b0);
    endtask
    task automatic rd(input logic [31:0] a);
        cycle(a, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] a, wd;
        int r;
        for (int i = 0; i < 6; i++) m[i] = 32'h0;
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(BASE + 32'h14, 32'h0, 1'b1, 1'b0, 1'b1);
        check("lit_rst_hit", {31'h0, last_hit}, 32'h1);
        rd(BASE + 32'h08);
        check("lit_rst_tcon", last_rd, 32'h0);
        check("lit_rst_irq", {31'h0, last_irq}, 32'h0);
        rd(BASE + 32'h14);
        check("lit_tick1", last_rd, 32'h1);
        idle(); idle();
        rd(BASE + 32'h14);
        check("lit_tick4", last_rd, 32'h4);
        wr(BASE + 32'h14, 32'h0);
        rd(BASE + 32'h14);
        check("lit_tick_ro", last_rd, 32'h6);

        wr(BASE + 32'h00, 32'hFFFF_FFF0);
        wr(BASE + 32'h04, 32'hFFFF_FFFE);
        wr(BASE + 32'h08, 32'h3);
        rd(BASE + 32'h04);
        check("lit_tl_fe", last_rd, 32'hFFFF_FFFE);
        rd(BASE + 32'h04);
        check("lit_tl_ff", last_rd, 32'hFFFF_FFFF);
        check("lit_irq_pre", {31'h0, last_irq}, 32'h0);
        rd(BASE + 32'h04);
        check("lit_tl_reload", last_rd, 32'hFFFF_FFF0);
        check("lit_irq_set", {31'h0, last_irq}, 32'h1);
        idle(); idle();
        wr(BASE + 32'h08, 32'h3);
        rd(BASE + 32'h08);
        check("lit_tcon_clr", last_rd, 32'h3);

        wr(BASE + 32'h04, 32'hFFFF_FFFF);
        wr(BASE + 32'h04, 32'h1234);
        rd(BASE + 32'h04);
        check("lit_tl_store_wins", last_rd, 32'h1234);
        rd(BASE + 32'h08);
        check("lit_tcon_irq", last_rd, 32'h7);
        wr(BASE + 32'h08, 32'h3);
        wr(BASE + 32'h04, 32'hFFFF_FFFF);
        wr(BASE + 32'h00, 32'h55);
        rd(BASE + 32'h04);
        check("lit_old_th_reload", last_rd, 32'hFFFF_FFF0);
        wr(BASE + 32'h08, 32'h0);

        cycle(BASE + 32'h18, 32'h0, 1'b1, 1'b0, 1'b0);
        check("lit_hit18", {31'h0, last_hit}, 32'h0);
        check("lit_rd18", last_rd, 32'h0);
        cycle(32'h5000_0000, 32'h0, 1'b1, 1'b0, 1'b0);
        check("lit_hit5", {31'h0, last_hit}, 32'h0);
        check("lit_rd5", last_rd, 32'h0);
        wr(BASE + 32'h18, 32'hDEAD_BEEF);
        wr(32'h5000_0000, 32'hDEAD_BEEF);
        rd(BASE + 32'h00);
        check("lit_th_kept", last_rd, 32'h55);

        wr(BASE + 32'h0E, 32'h1A5);
        rd(BASE + 32'h0C);
        check("lit_leds", {24'h0, last_leds}, 32'hA5);
        check("lit_led_rd", last_rd, 32'hA5);

        wr(BASE + 32'h08, 32'h3);
        idle(); idle();
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        rd(BASE + 32'h08);
        check("lit_rst_tcon2", last_rd, 32'h0);
        check("lit_rst_irq2", {31'h0, last_irq}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            rd(BASE + 32'h04);
            check("lit_tl_hold", last_rd, 32'h0);
        end

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            a = (r < 8) ? $urandom : BASE + {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
            wd = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
            if (a[4:2] == 3'd2 && $urandom_range(0, 1) == 1) wd = 32'h3;
            cycle(a, wd, 1'($urandom), 1'($urandom), r == 99);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
